// File: rtl/sram_dma_master_if.sv
// sram_dma_master_if: WishBone-style SRAM controller port (stb/addr/we/din out, dout/nak in)
interface sram_dma_master_if;
  logic        wb_stb;
  logic [31:0] wb_addr;
  logic [3:0]  wb_we;
  logic [31:0] wb_din;
  logic [47:0] wb_dout;
  logic        wb_nak;
  modport master (output wb_stb, wb_addr, wb_we, wb_din, input wb_dout, wb_nak);
  modport slave  (input wb_stb, wb_addr, wb_we, wb_din, output wb_dout, wb_nak);
endinterface

// File: rtl/sram_dma_master.sv
// sram_dma_master: SRAM block fill/copy initiator driving the SRAM controller wb port
// Ports: clk, rst (async, active-high); cmd_* command strobe and fields; busy/done/words_done status;
// wb (master modport) SRAM controller request port. Optional SRAM_DMA_CHECKSUM_EN adds checksum output.
module sram_dma_master #(
  parameter int          LEN_W     = 16,
  parameter int          ADDR_W    = 22,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_pattern,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
`ifdef SRAM_DMA_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  sram_dma_master_if.master wb
);
  localparam int AW = ADDR_W - 2;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t state, state_n;
  logic mode, mode_n, busy_n, done_n, stb, stb_n;
  logic [AW-1:0] src, src_n, dst, dst_n, a, a_n;
  logic [LEN_W-1:0] rem, rem_n, words_done_n;
  logic [31:0] pat, pat_n, din, din_n;
  logic [3:0] we, we_n;
`ifdef SRAM_DMA_CHECKSUM_EN
  logic [31:0] cs_n;
`endif
  logic unused;
  assign unused = ^{wb.wb_dout[47:32], cmd_src[1:0], cmd_dst[1:0]};
  assign wb.wb_stb  = stb;
  assign wb.wb_we   = we;
  assign wb.wb_din  = din;
  assign wb.wb_addr = {BASE_ADDR[31:ADDR_W], a, 2'b00};
  // wb_din doubles as the copy hold register: read data is loaded straight into it
  always_comb begin
    state_n      = state;
    mode_n       = mode;
    src_n        = src;
    dst_n        = dst;
    rem_n        = rem;
    pat_n        = pat;
    busy_n       = busy;
    done_n       = 1'b0;
    words_done_n = words_done;
    stb_n        = stb;
    we_n         = we;
    a_n          = a;
    din_n        = din;
`ifdef SRAM_DMA_CHECKSUM_EN
    cs_n         = checksum;
`endif
    case (state)
      IDLE: if (cmd_start) begin
        mode_n       = cmd_mode;
        src_n        = cmd_src[ADDR_W-1:2];
        dst_n        = cmd_dst[ADDR_W-1:2];
        rem_n        = cmd_len;
        pat_n        = cmd_pattern;
        words_done_n = '0;
`ifdef SRAM_DMA_CHECKSUM_EN
        cs_n         = '0;
`endif
        if (cmd_len == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          busy_n  = 1'b1;
          stb_n   = 1'b1;
          state_n = cmd_mode ? RD_REQ : WR_REQ;
          we_n    = cmd_mode ? 4'h0 : 4'hF;
          a_n     = cmd_mode ? cmd_src[ADDR_W-1:2] : cmd_dst[ADDR_W-1:2];
          din_n   = cmd_mode ? din : cmd_pattern;
        end
      end
      RD_REQ: if (wb.wb_nak) begin
        stb_n   = 1'b0;
        state_n = RD_WAIT;
      end
      RD_WAIT: if (!wb.wb_nak) begin
        src_n   = src + AW'(1);
        din_n   = wb.wb_dout[31:0];
        stb_n   = 1'b1;
        we_n    = 4'hF;
        a_n     = dst;
        state_n = WR_REQ;
`ifdef SRAM_DMA_CHECKSUM_EN
        cs_n    = checksum + wb.wb_dout[31:0];
`endif
      end
      WR_REQ: if (wb.wb_nak) begin
        stb_n   = 1'b0;
        state_n = WR_WAIT;
      end
      WR_WAIT: if (!wb.wb_nak) begin
        dst_n        = dst + AW'(1);
        words_done_n = words_done + LEN_W'(1);
        rem_n        = rem - LEN_W'(1);
        if (rem == LEN_W'(1)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          stb_n   = 1'b1;
          state_n = mode ? RD_REQ : WR_REQ;
          we_n    = mode ? 4'h0 : 4'hF;
          a_n     = mode ? src : dst + AW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      src        <= '0;
      dst        <= '0;
      rem        <= '0;
      pat        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      stb        <= 1'b0;
      we         <= 4'h0;
      a          <= '0;
      din        <= '0;
`ifdef SRAM_DMA_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_n;
      mode       <= mode_n;
      src        <= src_n;
      dst        <= dst_n;
      rem        <= rem_n;
      pat        <= pat_n;
      busy       <= busy_n;
      done       <= done_n;
      words_done <= words_done_n;
      stb        <= stb_n;
      we         <= we_n;
      a          <= a_n;
      din        <= din_n;
`ifdef SRAM_DMA_CHECKSUM_EN
      checksum   <= cs_n;
`endif
    end
endmodule

// File: tb/tb_sram_dma_master.sv
// tb_sram_dma_master: directed and random fill/copy ops against an SRAM responder and a word-level reference model
module tb_sram_dma_master;
  logic clk = 0, rst = 1, cmd_start = 0, cmd_mode = 0;
  logic [21:0] cmd_src = 0, cmd_dst = 0;
  logic [15:0] cmd_len = 0;
  logic [31:0] cmd_pattern = 0;
  logic busy, done;
  logic [15:0] words_done;
`ifdef SRAM_DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int ncmp = 0, nfail = 0, ph;
  bit [31:0] mem[int];
  logic [64:0] acc[$];
  sram_dma_master_if wbi();
  sram_dma_master dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .busy(busy), .done(done), .words_done(words_done),
`ifdef SRAM_DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .wb(wbi.master)
  );
  always #5 clk = ~clk;
  // SRAM controller: nak high for the two cycles after it sees stb, access performed as nak rises
  always @(negedge clk) begin
    if (rst) begin
      ph = 0;
      wbi.wb_nak = 1'b0;
      wbi.wb_dout = '0;
    end else case (ph)
      0: if (wbi.wb_stb) ph = 1;
      1: begin
        wbi.wb_nak = 1'b1;
        if (wbi.wb_we == 4'hF) begin
          mem[int'(wbi.wb_addr[21:2])] = wbi.wb_din;
          acc.push_back({1'b1, wbi.wb_addr, wbi.wb_din});
        end else begin
          wbi.wb_dout = {16'hABCD, mem.exists(int'(wbi.wb_addr[21:2])) ? mem[int'(wbi.wb_addr[21:2])] : 32'h0};
          acc.push_back({1'b0, wbi.wb_addr, wbi.wb_dout[31:0]});
        end
        ph = 2;
      end
      2: ph = 3;
      default: begin
        wbi.wb_nak = 1'b0;
        ph = 0;
      end
    endcase
  end
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input bit m, input logic [21:0] s, input logic [21:0] d, input logic [15:0] l,
                        input logic [31:0] p, input int inj, input string tag);
    bit [31:0] refm[int];
    logic [64:0] exp[$];
    logic [64:0] ga = 0, ge = 0;
    logic [31:0] v, sum = 0;
    int sw = int'(s[21:2]), dw = int'(d[21:2]);
    int a, b, cyc, dc = -1, nd = 0, stbc = 0, ed, mbad = 0;
    bit bbad = 0, found = 0;
    refm = mem;
    acc.delete();
    for (int i = 0; i < int'(l); i++) begin
      b = (dw + i) % (1 << 20);
      if (m) begin
        a = (sw + i) % (1 << 20);
        v = refm.exists(a) ? refm[a] : 32'h0;
        exp.push_back({1'b0, 32'(a * 4), v});
        sum += v;
      end else v = p;
      refm[b] = v;
      exp.push_back({1'b1, 32'(b * 4), v});
    end
    ed = (l == 0) ? 1 : (m ? 8 * int'(l) + 1 : 4 * int'(l) + 1);
    cmd_mode = m; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_pattern = p; cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
    cyc = 1;
    while (cyc < ed + 3) begin
      if (wbi.wb_stb) stbc++;
      if (done) begin
        nd++;
        if (dc < 0) dc = cyc;
      end
      if (busy !== (l != 0 && cyc < ed)) bbad = 1;
      if (cyc == inj) begin
        cmd_start = 1; cmd_dst = d ^ 22'h200; cmd_mode = ~m; cmd_len = l + 16'd1;
      end else cmd_start = 0;
      @(posedge clk); #1;
      cyc++;
    end
    cmd_start = 0;
    for (int i = 0; i < acc.size() && i < exp.size(); i++)
      if (!found && acc[i] !== exp[i]) begin
        found = 1; ga = acc[i]; ge = exp[i];
      end
    foreach (refm[k]) if (!mem.exists(k) || mem[k] !== refm[k]) mbad++;
    chk({tag, " done cycle"}, dc, ed);
    chk({tag, " done pulses"}, nd, 1);
    chk({tag, " busy profile bad"}, bbad, 0);
    chk({tag, " stb cycles"}, stbc, 2 * exp.size());
    chk({tag, " access count"}, acc.size(), exp.size());
    chk({tag, " access"}, ga, ge);
    chk({tag, " sram words wrong"}, mbad, 0);
    chk({tag, " words_done"}, words_done, l);
`ifdef SRAM_DMA_CHECKSUM_EN
    chk({tag, " checksum"}, checksum, m ? sum : 32'h0);
`endif
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset words_done", words_done, 0);
    chk("reset stb", wbi.wb_stb, 0);
    chk("reset we", wbi.wb_we, 0);
    chk("reset din", wbi.wb_din, 0);
    chk("reset addr", wbi.wb_addr, 0);
    rst = 0;
    @(posedge clk); #1;
    run_op(0, 22'h100, 22'h100, 4, 32'hDEADBEEF, -1, "fill4");
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    run_op(1, 22'h0, 22'h200, 3, 32'h0, -1, "copy3");
    chk("copy3 word 0x200", mem[32'h80], 1);
    chk("copy3 word 0x208", mem[32'h82], 3);
    run_op(0, 22'h400, 22'h400, 0, 32'h1234, -1, "len0");
    run_op(0, 22'h0, 22'h300, 3, $urandom, 6, "start_busy");
    run_op(0, 22'h0, 22'h340, 2, $urandom, 9, "start_done");
    run_op(0, 22'h0, 22'h3FFFF8, 3, 32'hA5A5_0001, -1, "wrap");
    chk("wrap word 0", mem[0], 32'hA5A5_0001);
    mem[32'h40] = 32'hFFFF_FFFF; mem[32'h41] = 32'h2;
    run_op(1, 22'h100, 22'h800, 2, 32'h0, -1, "csum");
`ifdef SRAM_DMA_CHECKSUM_EN
    chk("csum value", checksum, 32'h1);
`endif
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), 22'($urandom_range(0, 127)), 22'($urandom), 16'($urandom_range(1, 5)),
             $urandom, -1, "random");
    cmd_mode = 1; cmd_src = 22'h0; cmd_dst = 22'h1000; cmd_len = 4; cmd_start = 1;
    @(posedge clk); #1;
    cmd_start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midop stb before rst", wbi.wb_stb, 1);
    rst = 1;
    #1;
    chk("midop rst stb", wbi.wb_stb, 0);
    chk("midop rst busy", busy, 0);
    chk("midop rst words_done", words_done, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    run_op(0, 22'h0, 22'h2000, 2, 32'h0BAD_F00D, -1, "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
